// File: rtl/alu_shift_seq.sv
// -----------------------------------------------------------------------------
// alu_shift_seq
//   Multi-step shift / rotate / swap unit for the CB-prefix group. It sits
//   beside the main ALU, accepts one operation at a time over a valid/ready
//   handshake and returns the shifted value plus Z and C flags over a second
//   valid/ready handshake. N and H are not produced here (always 0 for this
//   group; the flag latch forces them).
//
//   Build option:
//     ALU_SHIFT_BARREL_EN defined   : whole cnt-step result is computed on the
//                                     accept edge; the unit goes straight to
//                                     DONE (SHIFT is never entered).
//     ALU_SHIFT_BARREL_EN undefined : iterative, one 1-bit step per cycle.
//   Results and flags are identical in both builds; only latency differs.
//
// Parameters
//   WIDTH  operand width (even, 8..32)
//   CW     count field width, derived from WIDTH (do not override)
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   abort      in   synchronous cancel of the operation in flight
//   in_valid   in   request valid
//   in_ready   out  request accepted when in_valid & in_ready
//   op         in   0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL
//   operand    in   value to shift
//   count      in   number of 1-bit steps (0 = pass-through, >WIDTH clamped)
//   carry_in   in   C flag before the operation
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts result
//   result     out  shifted value
//   flag_z     out  result == 0
//   flag_c     out  last bit shifted out
// -----------------------------------------------------------------------------
module alu_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [CW-1:0]    count,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c
);

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0]    ONE_CNT  = CW'(1);
  localparam logic [CW-1:0]    MAX_CNT  = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       op_hold;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [CW-1:0]    cnt_clamp;
  logic [WIDTH-1:0] swapped;
  logic [WIDTH:0]   step_val;

  // One 1-bit step; returns {carry_out, value}. SWAP never steps, so it
  // shares the pass-through default.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] a,
                                                input logic             ci);
    logic [WIDTH:0] r;
    case (f_op)
      OP_RLC:  r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_RRC:  r = {a[0], a[0], a[WIDTH-1:1]};
      OP_RL:   r = {a[WIDTH-1], a[WIDTH-2:0], ci};
      OP_RR:   r = {a[0], ci, a[WIDTH-1:1]};
      OP_SLA:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_SRL:  r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = {ci, a};
    endcase
    return r;
  endfunction

`ifdef ALU_SHIFT_BARREL_EN
  logic [WIDTH:0] barrel_val;

  // Unrolled chain of single steps; steps beyond n leave the value untouched,
  // so n == 0 naturally yields {carry_in, operand}.
  function automatic logic [WIDTH:0] shift_multi(input logic [2:0]       f_op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic             ci,
                                                 input logic [CW-1:0]    n);
    logic [WIDTH:0] r;
    r = {ci, a};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(n)) begin
        r = shift_step(f_op, r[WIDTH-1:0], r[WIDTH]);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Full multi-step result for the request currently presented.
  always_comb begin
    barrel_val = shift_multi(op, operand, carry_in, cnt_clamp);
  end
`endif

  // Request decode: accept strobe, clamped count, half swap, next iterative step.
  always_comb begin
    accept   = in_valid && (state == S_IDLE) && !abort;
    swapped  = {operand[WIDTH/2-1:0], operand[WIDTH-1:WIDTH/2]};
    step_val = shift_step(op_hold, acc, carry);
    if (count > MAX_CNT) begin
      cnt_clamp = MAX_CNT;
    end else begin
      cnt_clamp = count;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort always wins over completion or consumption.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_SWAP) begin
            next_state = S_DONE;
          end else begin
`ifdef ALU_SHIFT_BARREL_EN
            next_state = S_DONE;
`else
            if (cnt_clamp == ZERO_CNT) begin
              next_state = S_DONE;
            end else begin
              next_state = S_SHIFT;
            end
`endif
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (cnt == ONE_CNT) begin
          next_state = S_DONE;
        end else begin
          next_state = S_SHIFT;
        end
      end
      S_DONE: begin
        if (abort || out_ready) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DONE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (state == S_IDLE) && !abort;
    out_valid = (state == S_DONE);
  end

  // Datapath: working registers and the result/flag registers, which only
  // change on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_hold <= 3'd0;
      acc     <= ZERO_W;
      carry   <= 1'b0;
      cnt     <= ZERO_CNT;
      result  <= ZERO_W;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_hold <= op;
            acc     <= operand;
            carry   <= carry_in;
            cnt     <= cnt_clamp;
            if (op == OP_SWAP) begin
              result <= swapped;
              flag_z <= (swapped == ZERO_W);
              flag_c <= 1'b0;
            end
`ifdef ALU_SHIFT_BARREL_EN
            else begin
              result <= barrel_val[WIDTH-1:0];
              flag_z <= (barrel_val[WIDTH-1:0] == ZERO_W);
              flag_c <= barrel_val[WIDTH];
            end
`else
            else if (cnt_clamp == ZERO_CNT) begin
              result <= operand;
              flag_z <= (operand == ZERO_W);
              flag_c <= carry_in;
            end
`endif
          end
        end
        S_SHIFT: begin
          if (!abort) begin
            acc   <= step_val[WIDTH-1:0];
            carry <= step_val[WIDTH];
            cnt   <= cnt - ONE_CNT;
            if (cnt == ONE_CNT) begin
              result <= step_val[WIDTH-1:0];
              flag_z <= (step_val[WIDTH-1:0] == ZERO_W);
              flag_c <= step_val[WIDTH];
            end
          end
        end
        default: begin
          result <= result;
        end
      endcase
    end
  end

endmodule
